// File: rtl/data_memory_burst.sv
// data_memory_burst
// Backing data memory that sits under the data cache. It serves whole-line
// reads (line fills) and masked whole-line writes (write-backs), one request
// at a time. A programmable wait models main-memory access latency.
//
// Time-zero contents: the array holds each word as a difference from the
// power-up pattern rather than as the word itself. Because of this, the
// array's own power-up value is a uniform zero, which a plain declaration
// initializer can express. The logical content of word a is
// mem_delta[a] ^ init_word(a).

module data_memory_burst #(
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 15,
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 2,
   parameter int INIT_MODE  = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [WORD_W*LINE_WORDS-1:0] req_wdata,
   input  logic [LINE_WORDS-1:0]        req_wmask,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [WORD_W*LINE_WORDS-1:0] resp_rdata,
   output logic                         busy
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int LINE_W = WORD_W * LINE_WORDS;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   // Clears the word-within-line bits so that every access is line aligned.
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);
   localparam logic [7:0]        LAT_LOAD  = 8'(LATENCY);

   logic [1:0]              state;
   logic [7:0]              cnt;
   logic                    lat_we;
   logic [ADDR_W-1:0]       lat_base;
   logic [LINE_W-1:0]       lat_wdata;
   logic [LINE_WORDS-1:0]   lat_wmask;
   logic [LINE_W-1:0]       rd_line;

   logic [WORD_W-1:0] mem_delta [DEPTH] = '{default: '0};

   // Power-up value of word a: either zero or the word's own address,
   // truncated or zero-extended to WORD_W.
   function automatic logic [WORD_W-1:0] init_word(input logic [ADDR_W-1:0] a);
      if (INIT_MODE == 1) begin
         return WORD_W'(a);
      end
      return '0;
   endfunction

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP);
   assign busy       = (state != S_IDLE);

   // Capture the request only at the accept edge. After that, req_* may change freely.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req_valid) begin
         lat_we    <= req_we;
         lat_base  <= req_addr & LINE_MASK;
         lat_wdata <= req_wdata;
         lat_wmask <= req_wmask;
      end
   end

   // Assemble the addressed line, with the lowest address in the most significant word.
   always_comb begin
      rd_line = '0;
      for (int j = 0; j < LINE_WORDS; j++) begin
         rd_line[(LINE_WORDS-j)*WORD_W-1 -: WORD_W] =
            mem_delta[lat_base | ADDR_W'(j)] ^ init_word(lat_base | ADDR_W'(j));
      end
   end

   // Masked line write in the single ACCESS cycle. A reset before ACCESS
   // returns the FSM to IDLE, so a dropped write never reaches this point.
   always_ff @(posedge clk) begin
      if (state == S_ACCESS && lat_we) begin
         for (int j = 0; j < LINE_WORDS; j++) begin
            if (lat_wmask[LINE_WORDS-1-j]) begin
               mem_delta[lat_base | ADDR_W'(j)] <=
                  lat_wdata[(LINE_WORDS-j)*WORD_W-1 -: WORD_W] ^ init_word(lat_base | ADDR_W'(j));
            end
         end
      end
   end

   // Request FSM: accept, count down the latency, access once, then hold the response until it is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         resp_rdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  cnt   <= LAT_LOAD;
                  state <= (LATENCY > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               resp_rdata <= lat_we ? '0 : rd_line;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
